// File: rtl/mem_arb_pkg.sv
// Shared definitions for the cache-miss memory arbiter: FSM encoding,
// arbitration-mode constants and an index-width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // A single-channel build still needs a 1-bit index so ports never collapse to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational winner selection: round-robin from last_grant+1, or fixed
// priority with channel 0 highest. Output is one-hot, or zero with no request.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NCH = 2
) (
    input  logic [NCH-1:0]            req,
    input  logic [idx_width(NCH)-1:0] last_grant,
    input  logic                      mode,
    output logic [NCH-1:0]            gnt
);

    logic found;
    int   idx;

    // NOTE: every variable driven here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        if (mode) begin
            for (int i = 0; i < NCH; i++) begin
                if (req[i] && !found) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end else begin
            // Offset NCH wraps back to last_grant itself, so a lone requester can win twice in a row.
            for (int off = 1; off <= NCH; off++) begin
                idx = (int'(last_grant) + off) % NCH;
                if (req[idx] && !found) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates NCH cache-miss channels onto one slow block memory port.
// One transfer at a time: IDLE grants, BUSY holds the request, RESP returns data.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int AW       = 28,
    parameter int DW       = 128,
    parameter int ARB_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    ch_read,
    input  logic [NCH-1:0]    ch_write,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*DW-1:0] ch_wdata,
    output logic [DW-1:0]     ch_rdata,
    output logic [NCH-1:0]    ch_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    input  logic              mem_ready
);

    localparam int IW = idx_width(NCH);

    state_e        state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_grant_q, last_grant_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] resp_q, resp_d;

    logic [NCH-1:0] req_vec;
    logic [NCH-1:0] gnt;
    logic [IW-1:0]  win_idx;

    assign req_vec = ch_read | ch_write;

    rr_arbiter #(
        .NCH (NCH)
    ) u_rr_arbiter (
        .req        (req_vec),
        .last_grant (last_grant_q),
        .mode       (ARB_MODE == ARB_FIXED),
        .gnt        (gnt)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt[i]) begin
                win_idx = IW'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_d       = resp_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|req_vec) begin
                    grant_d      = win_idx;
                    last_grant_d = win_idx;
                    // A simultaneous read and write from one channel is served as the write.
                    mem_write_d  = ch_write[win_idx];
                    mem_read_d   = !ch_write[win_idx];
                    mem_addr_d   = ch_addr[int'(win_idx)*AW +: AW];
                    mem_wdata_d  = ch_wdata[int'(win_idx)*DW +: DW];
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    resp_d      = mem_rdata;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IW'(NCH - 1);
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_q       <= resp_d;
        end
    end

    // Gating with rst keeps a reset that lands in the RESP cycle from leaking a completion.
    always_comb begin
        ch_ready = '0;
        if (state_q == ST_RESP && !rst) begin
            ch_ready[grant_q] = 1'b1;
        end
    end

    assign ch_rdata  = resp_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one round-robin and one fixed-priority
// instance, each scenario in its own task with hand-computed expectations.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [1:0]   ch_read, ch_write;
    logic [55:0]  ch_addr;
    logic [255:0] ch_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic [127:0] ch_rdata;
    logic [1:0]   ch_ready;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;

    logic [1:0]   f_ch_read, f_ch_write;
    logic [55:0]  f_ch_addr;
    logic [255:0] f_ch_wdata;
    logic [127:0] f_mem_rdata;
    logic         f_mem_ready;
    logic [127:0] f_ch_rdata;
    logic [1:0]   f_ch_ready;
    logic         f_mem_read, f_mem_write;
    logic [27:0]  f_mem_addr;
    logic [127:0] f_mem_wdata;

    int vectors     = 0;
    int miscompares = 0;

    mem_arbiter #(.NCH(2), .AW(28), .DW(128), .ARB_MODE(0)) dut_rr (
        .clk(clk), .rst(rst),
        .ch_read(ch_read), .ch_write(ch_write), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_rdata(ch_rdata), .ch_ready(ch_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    mem_arbiter #(.NCH(2), .AW(28), .DW(128), .ARB_MODE(1)) dut_fx (
        .clk(clk), .rst(rst),
        .ch_read(f_ch_read), .ch_write(f_ch_write), .ch_addr(f_ch_addr), .ch_wdata(f_ch_wdata),
        .ch_rdata(f_ch_rdata), .ch_ready(f_ch_ready),
        .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
        .mem_rdata(f_mem_rdata), .mem_ready(f_mem_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a memory strobe, answers after lat cycles, returns what the RESP cycle showed.
    task automatic xact(input bit fx, input int lat, input logic [127:0] rd,
                        output int waited, output logic [1:0] rdy,
                        output logic [127:0] rdat, output logic [27:0] a);
        bit strobe;
        waited = 0;
        rdy    = '0;
        rdat   = '0;
        a      = '0;
        strobe = 1'b0;
        while (!strobe && waited < 12) begin
            tick();
            waited++;
            strobe = fx ? (f_mem_read | f_mem_write) : (mem_read | mem_write);
        end
        vectors++;
        if (!strobe) begin
            miscompares++;
            $display("FAIL xact_timeout: no memory strobe after %0d cycles (fx=%0d)", waited, fx);
            return;
        end
        a = fx ? f_mem_addr : mem_addr;
        for (int k = 1; k < lat; k++) tick();
        if (fx) begin f_mem_rdata = rd; f_mem_ready = 1'b1; end
        else    begin mem_rdata   = rd; mem_ready   = 1'b1; end
        tick();
        rdy  = fx ? f_ch_ready : ch_ready;
        rdat = fx ? f_ch_rdata : ch_rdata;
        mem_ready   = 1'b0;
        f_mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ch_read = '0; ch_write = '0; ch_addr = '0; ch_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        f_ch_read = '0; f_ch_write = '0; f_ch_addr = '0; f_ch_wdata = '0; f_mem_rdata = '0; f_mem_ready = 1'b0;
        tick();
        tick();
        vectors++;
        if ({mem_read, mem_write} !== 2'b00) begin
            miscompares++; $display("FAIL reset_strobes: got %b want 00", {mem_read, mem_write});
        end
        vectors++;
        if (mem_addr !== 28'h0 || mem_wdata !== 128'h0) begin
            miscompares++; $display("FAIL reset_addr_data: addr %h wdata %h want 0", mem_addr, mem_wdata);
        end
        vectors++;
        if (ch_ready !== 2'b00 || f_ch_ready !== 2'b00) begin
            miscompares++; $display("FAIL reset_ready: rr %b fx %b want 00", ch_ready, f_ch_ready);
        end
        vectors++;
        if (ch_rdata !== 128'h0) begin
            miscompares++; $display("FAIL reset_resp: got %h want 0", ch_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        int           w;
        logic [1:0]   r, exp_r;
        logic [127:0] d;
        logic [27:0]  a, exp_a;
        ch_addr = {28'h0000200, 28'h0000100};
        ch_read = 2'b11;
        for (int i = 0; i < 4; i++) begin
            xact(1'b0, 1, 128'h1000 + 128'(i), w, r, d, a);
            exp_r = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (i % 2 == 0) ? 28'h0000100 : 28'h0000200;
            vectors++;
            if (r !== exp_r || a !== exp_a) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: ready %b addr %h want %b %h", i, r, a, exp_r, exp_a);
            end
            vectors++;
            if (d !== 128'h1000 + 128'(i)) begin
                miscompares++; $display("FAIL rr_rdata[%0d]: got %h want %h", i, d, 128'h1000 + 128'(i));
            end
            vectors++;
            if (w !== ((i == 0) ? 1 : 2)) begin
                miscompares++;
                $display("FAIL rr_spacing[%0d]: strobe after %0d cycles want %0d", i, w, (i == 0) ? 1 : 2);
            end
        end
        ch_read = 2'b00;
        tick();
    endtask

    task automatic test_fixed_priority();
        int           w;
        logic [1:0]   r;
        logic [127:0] d;
        logic [27:0]  a;
        f_ch_addr = {28'h00000AB, 28'h00000CD};
        f_ch_read = 2'b11;
        for (int i = 0; i < 2; i++) begin
            xact(1'b1, 2, 128'h2000 + 128'(i), w, r, d, a);
            vectors++;
            if (r !== 2'b01 || a !== 28'h00000CD || d !== 128'h2000 + 128'(i)) begin
                miscompares++;
                $display("FAIL fx_ch0[%0d]: ready %b addr %h rdata %h want 01 0cd %h", i, r, a, d, 128'h2000 + 128'(i));
            end
        end
        f_ch_read = 2'b10;
        xact(1'b1, 2, 128'h2FFF, w, r, d, a);
        vectors++;
        if (r !== 2'b10 || a !== 28'h00000AB || d !== 128'h2FFF) begin
            miscompares++;
            $display("FAIL fx_ch1: ready %b addr %h rdata %h want 10 0ab 2fff", r, a, d);
        end
        f_ch_read = 2'b00;
        tick();
    endtask

    task automatic test_single_read();
        ch_addr[27:0] = 28'h0000010;
        ch_read = 2'b01;
        tick();
        vectors++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h0000010 || ch_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL single_issue: rd %b wr %b addr %h ready %b want 1 0 0000010 00", mem_read, mem_write, mem_addr, ch_ready);
        end
        tick(); tick(); tick();
        vectors++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000010) begin
            miscompares++; $display("FAIL single_hold: rd %b addr %h want 1 0000010", mem_read, mem_addr);
        end
        mem_rdata = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0F1E_2D3C;
        mem_ready = 1'b1;
        tick();
        vectors++;
        if (ch_ready !== 2'b01 || ch_rdata !== 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0F1E_2D3C || mem_read !== 1'b0) begin
            miscompares++;
            $display("FAIL single_resp: ready %b rdata %h rd %b want 01 cafef00d... 0", ch_ready, ch_rdata, mem_read);
        end
        ch_read = 2'b00;
        mem_ready = 1'b0;
        tick();
        vectors++;
        if (ch_ready !== 2'b00) begin
            miscompares++; $display("FAIL single_pulse: ready %b want 00", ch_ready);
        end
    endtask

    task automatic test_write_priority();
        ch_addr[55:28]   = 28'h0000330;
        ch_wdata[255:128] = 128'hA5;
        ch_read  = 2'b10;
        ch_write = 2'b10;
        tick();
        vectors++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== 128'hA5 || mem_addr !== 28'h0000330) begin
            miscompares++;
            $display("FAIL wr_issue: wr %b rd %b wdata %h addr %h want 1 0 a5 0000330", mem_write, mem_read, mem_wdata, mem_addr);
        end
        ch_read = 2'b00;
        ch_write = 2'b00;
        ch_addr[55:28]    = 28'h0000444;
        ch_wdata[255:128] = 128'h5A;
        tick();
        vectors++;
        if (mem_write !== 1'b1 || mem_wdata !== 128'hA5 || mem_addr !== 28'h0000330) begin
            miscompares++;
            $display("FAIL wr_hold: wr %b wdata %h addr %h want 1 a5 0000330", mem_write, mem_wdata, mem_addr);
        end
        mem_ready = 1'b1;
        tick();
        vectors++;
        if (ch_ready !== 2'b10 || mem_write !== 1'b0) begin
            miscompares++; $display("FAIL wr_resp: ready %b wr %b want 10 0", ch_ready, mem_write);
        end
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_busy();
        ch_addr = {28'h0000200, 28'h0000100};
        ch_read = 2'b11;
        tick();
        vectors++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000100) begin
            miscompares++; $display("FAIL rb_grant: rd %b addr %h want 1 0000100", mem_read, mem_addr);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (mem_read !== 1'b0 || ch_ready !== 2'b00) begin
            miscompares++; $display("FAIL rb_abort: rd %b ready %b want 0 00", mem_read, ch_ready);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000100 || ch_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL rb_regrant: rd %b addr %h ready %b want 1 0000100 00", mem_read, mem_addr, ch_ready);
        end
        mem_rdata = 128'h7777;
        mem_ready = 1'b1;
        tick();
        vectors++;
        if (ch_ready !== 2'b01 || ch_rdata !== 128'h7777) begin
            miscompares++; $display("FAIL rb_resp: ready %b rdata %h want 01 7777", ch_ready, ch_rdata);
        end
        ch_read = 2'b00;
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_idle_mem_ready();
        ch_read = 2'b00;
        mem_rdata = 128'hFFFF_FFFF;
        mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (ch_ready !== 2'b00 || mem_read !== 1'b0 || mem_write !== 1'b0 || ch_rdata !== 128'h7777) begin
                miscompares++;
                $display("FAIL idle_ready[%0d]: ready %b rd %b wr %b rdata %h want 00 0 0 7777", i, ch_ready, mem_read, mem_write, ch_rdata);
            end
        end
        mem_ready = 1'b0;
        ch_addr[27:0] = 28'h0000ABC;
        ch_read = 2'b01;
        tick();
        vectors++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000ABC) begin
            miscompares++; $display("FAIL idle_then_grant: rd %b addr %h want 1 0000abc", mem_read, mem_addr);
        end
        mem_ready = 1'b1;
        tick();
        vectors++;
        if (ch_ready !== 2'b01) begin
            miscompares++; $display("FAIL idle_then_resp: ready %b want 01", ch_ready);
        end
        ch_read = 2'b00;
        mem_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_single_read();
        test_write_priority();
        test_reset_busy();
        test_idle_mem_ready();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
